// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: drives the regfile read ports, bypasses its write port,
// and holds one decoded instruction in the ID/EX register with a load-use interlock.
module id_operand_stage #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [W-1:0]         in_pc,
  output logic [$clog2(N)-1:0] rf_raddr1,
  output logic [$clog2(N)-1:0] rf_raddr2,
  input  logic [W-1:0]         rf_rdata1,
  input  logic [W-1:0]         rf_rdata2,
  input  logic                 wb_wen,
  input  logic [$clog2(N)-1:0] wb_waddr,
  input  logic [W-1:0]         wb_wdata,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_pc,
  output logic [W-1:0]         out_rs1_val,
  output logic [W-1:0]         out_rs2_val,
  output logic [W-1:0]         out_imm,
  output logic [$clog2(N)-1:0] out_rs1,
  output logic [$clog2(N)-1:0] out_rs2,
  output logic [$clog2(N)-1:0] out_rd,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic                 out_funct7b5,
  output logic [31:0]          bubble_cnt
);

  localparam int AW = $clog2(N);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {EMPTY, FULL} state_t;

  function automatic logic [W-1:0] imm_gen(input logic [31:0] instr);
    logic signed [31:0] imm;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:         imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'h000};
      OP_JAL:           imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:          imm = '0;
    endcase
    return W'(imm);
  endfunction

  // x0 reads as zero and is never bypassed, even when the write port targets it.
  function automatic logic [W-1:0] sel_operand(input logic [AW-1:0] idx,
                                               input logic [W-1:0]  rdata,
                                               input logic          wen,
                                               input logic [AW-1:0] waddr,
                                               input logic [W-1:0]  wdata);
    if (idx == '0)                  return '0;
    else if (wen && waddr == idx)   return wdata;
    else                            return rdata;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t          state_p1, state_nxt;
  logic [W-1:0]    pc_p1, rs1_val_p1, rs2_val_p1, imm_p1;
  logic [AW-1:0]   rs1_p1, rs2_p1, rd_p1;
  logic [6:0]      opcode_p1;
  logic [2:0]      funct3_p1;
  logic            f7b5_p1;
  logic [31:0]     bubble_p1;

  logic [6:0]      opcode;
  logic [AW-1:0]   src1, src2, dst;
  logic            rs1_used, rs2_used, lu_hit, advance, capture, bubble, hold;

  assign opcode    = in_instr[6:0];
  assign dst       = in_instr[7 +: AW];
  assign src1      = in_instr[15 +: AW];
  assign src2      = in_instr[20 +: AW];
  assign rf_raddr1 = src1;
  assign rf_raddr2 = src2;

  always_comb begin
    rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    rs2_used = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
    lu_hit   = (state_p1 == FULL) && (opcode_p1 == OP_LOAD) && (rd_p1 != '0) &&
               ((rs1_used && rd_p1 == src1) || (rs2_used && rd_p1 == src2));
  end

  always_comb begin
    state_nxt = state_p1;
    bubble    = 1'b0;
    advance   = (state_p1 == FULL) && out_ready;
    in_ready  = !reset && !flush && !lu_hit && ((state_p1 == EMPTY) || out_ready);
    capture   = in_valid && in_ready;
    hold      = (state_p1 == FULL) && !advance && !flush;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (capture) begin
      state_nxt = FULL;
    end else if (advance) begin
      state_nxt = EMPTY;
      bubble    = lu_hit;
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= EMPTY;
      bubble_p1  <= '0;
      pc_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      opcode_p1  <= '0;
      funct3_p1  <= '0;
      f7b5_p1    <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (bubble) bubble_p1 <= sat_inc(bubble_p1);
      if (capture) begin
        pc_p1      <= in_pc;
        rs1_val_p1 <= sel_operand(src1, rf_rdata1, wb_wen, wb_waddr, wb_wdata);
        rs2_val_p1 <= sel_operand(src2, rf_rdata2, wb_wen, wb_waddr, wb_wdata);
        imm_p1     <= imm_gen(in_instr);
        rs1_p1     <= src1;
        rs2_p1     <= src2;
        rd_p1      <= dst;
        opcode_p1  <= opcode;
        funct3_p1  <= in_instr[14:12];
        f7b5_p1    <= in_instr[30];
      end else if (hold && wb_wen && wb_waddr != '0) begin
        // A stalled entry must not keep a stale operand once writeback updates it.
        if (wb_waddr == rs1_p1) rs1_val_p1 <= wb_wdata;
        if (wb_waddr == rs2_p1) rs2_val_p1 <= wb_wdata;
      end
    end
  end

  assign out_valid    = (state_p1 == FULL);
  assign out_pc       = pc_p1;
  assign out_rs1_val  = rs1_val_p1;
  assign out_rs2_val  = rs2_val_p1;
  assign out_imm      = imm_p1;
  assign out_rs1      = rs1_p1;
  assign out_rs2      = rs2_p1;
  assign out_rd       = rd_p1;
  assign out_opcode   = opcode_p1;
  assign out_funct3   = funct3_p1;
  assign out_funct7b5 = f7b5_p1;
  assign bubble_cnt   = bubble_p1;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: a reference model pushes expected ID/EX entries,
// a monitor pops and compares them whenever the stage presents one.
module tb_id_operand_stage;
  localparam int N = 32;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, wb_wen, flush, out_valid, out_ready, out_funct7b5;
  logic [31:0]   in_instr, bubble_cnt;
  logic [W-1:0]  in_pc, rf_rdata1, rf_rdata2, wb_wdata;
  logic [W-1:0]  out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]    rf_raddr1, rf_raddr2, wb_waddr, out_rs1, out_rs2, out_rd;
  logic [6:0]    out_opcode;
  logic [2:0]    out_funct3;

  always #5 clk = ~clk;

  id_operand_stage #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .bubble_cnt(bubble_cnt)
  );

  // Register file contents seen through the stage's read ports.
  logic [W-1:0] rf [N];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  typedef struct packed {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } ent_t;

  ent_t        sb[$];
  ent_t        m_held;
  bit          m_full = 1'b0;
  bit          chk_zero = 1'b0;
  logic [31:0] m_bub = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value computed arithmetically from the instruction's bit fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int s;
    s = $signed(i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return s >>> 20;
      7'h23: return (s >>> 25) * 32 + int'(i[11:7]);
      7'h63: return (s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'h37, 7'h17: return int'(i[31:12]) * 4096;
      7'h6F: return (s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_lu(input bit full, input ent_t h, input logic [31:0] i);
    bit use1, use2;
    use1 = !(i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h6F);
    use2 = (i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63);
    return full && h.op == 7'h03 && h.rd != 0 &&
           ((use1 && h.rd == i[19:15]) || (use2 && h.rd == i[24:20]));
  endfunction

  function automatic logic [31:0] ref_opnd(input logic [4:0] idx);
    if (idx == 0) return 0;
    if (wb_wen && wb_waddr == idx) return wb_wdata;
    return rf[idx];
  endfunction

  task automatic model_loop();
    ent_t e;
    bit adv, lu, rdy;
    forever begin
      @(posedge clk);
      chk_zero = reset;
      if (reset) begin
        m_full = 0;
        m_bub  = 0;
        sb.delete();
      end else begin
        adv = m_full && out_ready;
        lu  = ref_lu(m_full, m_held, in_instr);
        rdy = !flush && !lu && (!m_full || out_ready);
        if (flush) begin
          m_full = 0;
          sb.delete();
        end else if (in_valid && rdy) begin
          e.pc = in_pc; e.rs1 = in_instr[19:15]; e.rs2 = in_instr[24:20]; e.rd = in_instr[11:7];
          e.op = in_instr[6:0]; e.f3 = in_instr[14:12]; e.f7 = in_instr[30];
          e.imm = ref_imm(in_instr); e.rs1v = ref_opnd(e.rs1); e.rs2v = ref_opnd(e.rs2);
          sb.push_back(e);
          m_held = e;
          m_full = 1;
        end else if (adv) begin
          m_full = 0;
          if (lu && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
        end else if (m_full && sb.size() > 0 && wb_wen && wb_waddr != 0) begin
          e = sb[0];
          if (wb_waddr == e.rs1) e.rs1v = wb_wdata;
          if (wb_waddr == e.rs2) e.rs2v = wb_wdata;
          sb[0] = e;
        end
      end
      if (wb_wen && wb_waddr != 0) rf[wb_waddr] = wb_wdata;
    end
  endtask

  task automatic monitor_loop();
    ent_t e;
    bit   exp_rdy;
    forever begin
      @(negedge clk);
      #2;
      exp_rdy = !reset && !flush && !ref_lu(m_full, m_held, in_instr) && (!m_full || out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("bubble_cnt", bubble_cnt, m_bub);
      check("rf_raddr1", rf_raddr1, in_instr[19:15]);
      check("rf_raddr2", rf_raddr2, in_instr[24:20]);
      if (chk_zero) begin
        check("rst_pc", out_pc, 0);
        check("rst_rs1_val", out_rs1_val, 0);
        check("rst_rs2_val", out_rs2_val, 0);
        check("rst_imm", out_imm, 0);
        check("rst_fields", {out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7b5}, 0);
      end
      check("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0 && out_valid) begin
        e = sb[0];
        check("out_pc", out_pc, e.pc);
        check("out_rs1_val", out_rs1_val, e.rs1v);
        check("out_rs2_val", out_rs2_val, e.rs2v);
        check("out_imm", out_imm, e.imm);
        check("out_regs", {out_rs1, out_rs2, out_rd}, {e.rs1, e.rs2, e.rd});
        check("out_decode", {out_opcode, out_funct3, out_funct7b5}, {e.op, e.f3, e.f7});
        if (out_ready) void'(sb.pop_front());
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic wen, input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = $urandom(); out_ready = ordy;
    wb_wen = wen; wb_waddr = wa; wb_wdata = wd; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h03;  3: r[6:0] = 7'h03;
      4: r[6:0] = 7'h23;  5: r[6:0] = 7'h63;  6: r[6:0] = 7'h37;  7: r[6:0] = 7'h17;
      8: r[6:0] = 7'h6F;  9: r[6:0] = 7'h67;  default: r[6:0] = 7'h73;
    endcase
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    logic [31:0] x2_val, ins;
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0; flush = 0;
    for (int i = 0; i < N; i++) rf[i] = (i == 0) ? 32'h0 : $urandom();
    fork
      model_loop();
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    reset = 0;

    // Same-cycle writeback bypass into rs1.
    x2_val = rf[2];
    step(1, 32'h002081B3, 1, 1, 5'd1, 32'hA5A5A5A5, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    #3;
    check("bypass_rs1", out_rs1_val, 32'hA5A5A5A5);
    check("bypass_rs2", out_rs2_val, x2_val);
    check("bypass_rd", out_rd, 3);

    // Write to x0 is not bypassed.
    step(1, 32'hFFF00293, 1, 1, 5'd0, 32'h1234, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    #3;
    check("x0_rs1_val", out_rs1_val, 0);
    check("x0_imm", out_imm, 32'hFFFFFFFF);

    // Load-use bubble.
    step(1, 32'h00012083, 0, 0, 0, 0, 0);
    step(1, 32'h004081B3, 1, 0, 0, 0, 0);
    #3 check("lu_in_ready", in_ready, 0);
    step(1, 32'h004081B3, 1, 0, 0, 0, 0);
    #3;
    check("lu_bubble_valid", out_valid, 0);
    check("lu_bubble_cnt", bubble_cnt, 1);
    check("lu_accept_ready", in_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    #3 check("lu_add_rd", out_rd, 3);

    // Backpressure with operand refresh on the held entry.
    step(1, 32'h002081B3, 1, 0, 0, 0, 0);
    step(1, 32'h00000013, 0, 0, 0, 0, 0);
    #3 check("bp_ready_c1", in_ready, 0);
    step(1, 32'h00000013, 0, 1, 5'd1, 32'h5A5A5A5A, 0);
    #3 check("bp_ready_c2", in_ready, 0);
    step(1, 32'h00000013, 0, 0, 0, 0, 0);
    #3;
    check("bp_ready_c3", in_ready, 0);
    check("bp_refresh", out_rs1_val, 32'h5A5A5A5A);
    check("bp_rd", out_rd, 3);

    // Flush blocks capture and empties the stage.
    step(1, 32'h00000013, 0, 0, 0, 0, 1);
    #3 check("flush_ready", in_ready, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #3 check("flush_valid", out_valid, 0);

    // Immediate formats, back to back.
    step(1, 32'h0020A423, 1, 0, 0, 0, 0);
    step(1, 32'hFE000CE3, 1, 0, 0, 0, 0);
    #3 check("imm_sw", out_imm, 32'h00000008);
    step(1, 32'h123450B7, 1, 0, 0, 0, 0);
    #3 check("imm_beq", out_imm, 32'hFFFFFFF8);
    step(1, 32'hFFDFF0EF, 1, 0, 0, 0, 0);
    #3 check("imm_lui", out_imm, 32'h12345000);
    step(0, 0, 1, 0, 0, 0, 0);
    #3 check("imm_jal", out_imm, 32'hFFFFFFFC);

    // Randomized traffic, including occasional flush and mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      ins = rand_instr();
      if ($urandom_range(0, 9) < 7)
        step(1, ins, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), $urandom(), ($urandom_range(0, 19) == 0));
      else
        step(0, 0, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), $urandom(), ($urandom_range(0, 19) == 0));
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 0;
    repeat (4) step(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
